// File: rtl/delay_line_buf.sv
// Programmable delay line (1..MAX_DLY cycles) with per-stage valid tracking.
// Define DLY_BUF_BYPASS_EN to allow dly_sel=0 as a combinational bypass.
module delay_line_buf #(
    parameter int WIDTH   = 8,
    parameter int MAX_DLY = 16,
    localparam int DW     = $clog2(MAX_DLY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    input  logic [DW-1:0]    dly_sel,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    output logic [DW-1:0]    occ,
    output logic             err
);

    logic [MAX_DLY-1:0][WIDTH-1:0] data_q;
    logic [MAX_DLY-1:0]            vld_q;
    logic [DW-1:0]                 dly_cur;
    logic [DW-1:0]                 sel_c;
    logic                          oor;
    logic                          err_q;

    assign oor = dly_sel > DW'(MAX_DLY);
    assign err = err_q;

    always_comb begin
        sel_c = dly_sel;
        if (oor) begin
            sel_c = DW'(MAX_DLY);
        end
`ifndef DLY_BUF_BYPASS_EN
        else if (dly_sel == '0) begin
            sel_c = DW'(1);
        end
`endif
    end

    // A delay change flushes the valid bits so no sample leaves early or late.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            vld_q   <= '0;
            dly_cur <= DW'(1);
            err_q   <= 1'b0;
        end else begin
            if (oor) begin
                err_q <= 1'b1;
            end
            if (sel_c != dly_cur) begin
                dly_cur <= sel_c;
                vld_q   <= '0;
            end else if (en) begin
                data_q <= {data_q[MAX_DLY-2:0], in_data};
                vld_q  <= {vld_q[MAX_DLY-2:0], in_vld};
            end
        end
    end

    always_comb begin
        out_vld  = 1'b0;
        out_data = '0;
        occ      = '0;
        for (int i = 0; i < MAX_DLY; i++) begin
            if (dly_cur == DW'(i + 1)) begin
                out_vld  = vld_q[i];
                out_data = data_q[i];
            end
            if (DW'(i) < dly_cur) begin
                occ = occ + DW'(vld_q[i]);
            end
        end
`ifdef DLY_BUF_BYPASS_EN
        if (dly_cur == '0) begin
            out_vld  = in_vld & en;
            out_data = in_data;
        end
`endif
    end

endmodule

// File: tb/tb_delay_line_buf.sv
// Randomized + directed bench for delay_line_buf against a capture-log model.
// Expected outputs derive from capture history indexed by advance count.
module tb_delay_line_buf;

    localparam int WIDTH   = 8;
    localparam int MAX_DLY = 16;
    localparam int DW      = $clog2(MAX_DLY + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             in_vld;
    logic [WIDTH-1:0] in_data;
    logic [DW-1:0]    dly_sel;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic [DW-1:0]    occ;
    logic             err;

    int n_run  = 0;
    int n_fail = 0;

    // Model: every advancing edge logs its capture under a running index.
    int               adv;
    int               vfrom;
    int               m_d;
    bit               m_err;
    bit               vlog[int];
    logic [WIDTH-1:0] dlog[int];

    delay_line_buf #(.WIDTH(WIDTH), .MAX_DLY(MAX_DLY)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .in_vld  (in_vld),
        .in_data (in_data),
        .dly_sel (dly_sel),
        .out_vld (out_vld),
        .out_data(out_data),
        .occ     (occ),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int s;
        int c;
        if (rst) begin
            adv   = 0;
            vfrom = 1;
            m_d   = 1;
            m_err = 1'b0;
            vlog.delete();
            dlog.delete();
        end else begin
            s = int'(dly_sel);
            c = (s > MAX_DLY) ? MAX_DLY : s;
`ifndef DLY_BUF_BYPASS_EN
            if (c == 0) c = 1;
`endif
            if (s > MAX_DLY) m_err = 1'b1;
            if (c != m_d) begin
                m_d   = c;
                vfrom = adv + 1;
            end else if (en) begin
                adv++;
                vlog[adv] = in_vld;
                dlog[adv] = in_data;
            end
        end
    endtask

    task automatic check_all(string tag);
        int               idx;
        int               j;
        logic             ev;
        logic [WIDTH-1:0] ed;
        int               eo;
        ev = 1'b0;
        ed = '0;
        eo = 0;
        if (m_d == 0) begin
            ev = in_vld & en;
            ed = in_data;
        end else begin
            idx = adv - (m_d - 1);
            if (idx >= 1) begin
                ed = dlog[idx];
                ev = vlog[idx] && (idx >= vfrom);
            end
            for (int k = 0; k < m_d; k++) begin
                j = adv - k;
                if (j >= 1 && j >= vfrom && vlog[j]) eo++;
            end
        end
        chk({tag, ".vld"}, 32'(out_vld), 32'(ev));
        if (ev || vfrom == 1) chk({tag, ".data"}, 32'(out_data), 32'(ed));
        chk({tag, ".occ"}, 32'(occ), eo);
        chk({tag, ".err"}, 32'(err), 32'(m_err));
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        dly_sel = DW'(1);
        tick("rst");
        chk("rst.vld0", 32'(out_vld), 0);
        chk("rst.data0", 32'(out_data), 0);
        chk("rst.occ0", 32'(occ), 0);
        rst = 1'b0;

        // Single pulse at delay 4
        dly_sel = DW'(4);
        en      = 1'b1;
        tick("p.cfg");
        for (int i = 0; i < 3; i++) tick("p.idle");
        in_vld  = 1'b1;
        in_data = 8'hA5;
        tick("p.cap");
        in_vld  = 1'b0;
        in_data = 8'h00;
        tick("p.w1");
        tick("p.w2");
        tick("p.out");
        chk("p.peak_vld", 32'(out_vld), 1);
        chk("p.peak_data", 32'(out_data), 32'h A5);
        chk("p.peak_occ", 32'(occ), 1);
        tick("p.gone");
        chk("p.gone_vld", 32'(out_vld), 0);

        // Continuous stream at delay 3
        dly_sel = DW'(3);
        tick("s.cfg");
        for (int i = 1; i <= 20; i++) begin
            in_vld  = 1'b1;
            in_data = WIDTH'(i);
            tick("s.run");
        end
        chk("s.occ3", 32'(occ), 3);

        // Stall mid-stream at delay 4
        dly_sel = DW'(4);
        tick("h.cfg");
        for (int i = 0; i < 6; i++) begin
            in_data = WIDTH'(8'h40 + i);
            tick("h.pre");
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = WIDTH'(8'h80 + i);
            tick("h.stall");
        end
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = WIDTH'(8'h50 + i);
            tick("h.post");
        end

        // Reconfigure 4 -> 2 with samples in flight
        in_vld = 1'b0;
        tick("r.gap");
        for (int i = 0; i < 3; i++) begin
            in_vld  = 1'b1;
            in_data = WIDTH'(8'hC0 + i);
            tick("r.fill");
        end
        in_vld  = 1'b0;
        dly_sel = DW'(2);
        tick("r.cfg");
        chk("r.flush_occ", 32'(occ), 0);
        for (int i = 0; i < 5; i++) tick("r.drain");
        in_vld  = 1'b1;
        in_data = 8'h77;
        tick("r.new");
        in_vld = 1'b0;
        tick("r.lat2");
        chk("r.lat2_data", 32'(out_data), 32'h77);

        // Out-of-range request clamps and latches err
        dly_sel = DW'(MAX_DLY + 1);
        tick("e.cfg");
        chk("e.set", 32'(err), 1);
        for (int i = 0; i < MAX_DLY + 3; i++) begin
            in_vld  = (i == 0);
            in_data = 8'h5A;
            tick("e.run");
        end
        dly_sel = DW'(2);
        tick("e.sticky");
        chk("e.sticky", 32'(err), 1);
        rst = 1'b1;
        tick("e.rst");
        chk("e.clr", 32'(err), 0);
        rst = 1'b0;

        // dly_sel = 0
        dly_sel = '0;
        tick("z.cfg");
        in_vld  = 1'b1;
        in_data = 8'h3C;
        tick("z.cap");
        in_vld = 1'b0;
        tick("z.after");

        // Randomized traffic with rare reconfigs and resets
        for (int i = 0; i < 600; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            in_vld  = $urandom_range(0, 1);
            in_data = WIDTH'($urandom);
            if ($urandom_range(0, 29) == 0) dly_sel = DW'($urandom_range(0, MAX_DLY + 4));
            rst = ($urandom_range(0, 99) == 0);
            tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_line_buf.md
DELAY_LINE_BUF -- requirements
Module: delay_line_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter MAX_DLY, default 16, maximum delay in clock cycles (>=2).
REQ-003 SHALL have derived localparam DW = $clog2(MAX_DLY+1), the width of dly_sel and occ.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port en  input  1  advance enable; 0 freezes the line.
REQ-007 SHALL have port in_vld  input  1  input sample valid.
REQ-008 SHALL have port in_data  input  WIDTH  input sample.
REQ-009 SHALL have port dly_sel  input  DW  requested delay in cycles.
REQ-010 SHALL have port out_vld  output  1  delayed valid.
REQ-011 SHALL have port out_data  output  WIDTH  delayed sample.
REQ-012 SHALL have port occ  output  DW  count of valid samples in active stages.
REQ-013 SHALL have port err  output  1  sticky flag for an out-of-range delay request.

Function
REQ-014 SHALL implement MAX_DLY stages, each holding one data register and one valid bit; stage 0 loads from in_vld/in_data.
REQ-015 SHALL hold the active delay d in internal register dly_cur, range 1..MAX_DLY; out_vld/out_data SHALL be driven from stage d-1.
REQ-016 SHALL shift every stage by one position on each edge with en=1; stage 0 SHALL capture in_vld and in_data.
REQ-017 SHALL give fixed latency: a sample captured at edge N with en=1 on all following edges SHALL be presented on the outputs after edge N+d-1 and until edge N+d.
REQ-018 SHALL, when en=0, hold all stages, out_vld, out_data and occ unchanged and ignore in_vld.
REQ-019 SHALL, when out_vld=0, leave out_data as the stale contents of stage d-1 (no qualification required).
REQ-020 SHALL clamp dly_sel > MAX_DLY to MAX_DLY and set err on that edge; err SHALL stay 1 until rst.
REQ-021 SHALL, when the clamped dly_sel differs from dly_cur at an edge (regardless of en), load dly_cur, clear every valid bit, and drop the sample presented on that edge.
REQ-022 SHALL therefore produce no out_vld for at least d edges after reconfiguration; data registers need not be cleared.
REQ-023 SHALL compute occ combinationally as the popcount of valid bits in stages 0..d-1; the range is 0..d.
REQ-024 SHALL give rst priority over en, reconfiguration and capture.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, clear all valid bits and data registers to 0 and load dly_cur with 1.
REQ-026 SHALL also clear err to 0 on that reset edge.
REQ-027 SHALL hold out_vld=0, out_data=0 and occ=0 on the cycle following reset.
REQ-028 SHALL, on reset mid-operation, discard all in-flight samples with no output.

Configuration
REQ-029 SHALL support macro DLY_BUF_BYPASS_EN.
REQ-030 SHALL, when DLY_BUF_BYPASS_EN is defined, treat dly_sel=0 as valid, with dly_cur range 0..MAX_DLY.
REQ-031 SHALL, when DLY_BUF_BYPASS_EN is defined and dly_cur=0, drive out_vld=in_vld&en and out_data=in_data combinationally, with occ=0.
REQ-032 SHALL, when DLY_BUF_BYPASS_EN is undefined, map dly_sel=0 to d=1 without setting err; no combinational path from input to output SHALL exist.

Verification
REQ-033 SHALL cover: rst, dly_sel=4, en=1, in_vld pulse with in_data=0xA5 at edge 10 -> out_vld=1 and out_data=0xA5 only between edges 13 and 14; occ peaks at 1.
REQ-034 SHALL cover: dly_sel=3, continuous in_vld with data 1,2,3,... -> out_data 1,2,3,... every cycle starting 2 edges after the first capture; occ steady at 3.
REQ-035 SHALL cover: stream at d=4 with en=0 for 5 cycles mid-stream -> outputs and occ frozen; the sequence resumes with no loss or duplication.
REQ-036 SHALL cover: dly_sel change 4->2 with 3 samples in flight -> occ=0 the next cycle; those samples are never output; a new sample appears with latency 2.
REQ-037 SHALL cover: dly_sel=MAX_DLY+1 (requires MAX_DLY+1 <= 2^DW-1, e.g. MAX_DLY=5) -> err=1 stays set; latency equals MAX_DLY; rst clears err.
REQ-038 SHALL cover, with DLY_BUF_BYPASS_EN defined: dly_sel=0, in_data=0x3C, in_vld=1, en=1 -> out_data=0x3C and out_vld=1 in the same cycle; without the macro, out_vld=1 one cycle later.
